// File: rtl/ipsxb_fft_pingpong_pkg.sv
// Shared constants and helpers for the FFT ping-pong frame buffer.
// Bank count, fill-counter sizing and read-latency selection.
package ipsxb_fft_pingpong_pkg;

    localparam int unsigned NUM_BANKS  = 2;
    localparam int unsigned BANK_W     = $clog2(NUM_BANKS);
    localparam int unsigned FULL_CNT_W = $clog2(NUM_BANKS + 1);

    localparam logic [FULL_CNT_W-1:0] FULL_CNT_EMPTY = FULL_CNT_W'(0);
    localparam logic [FULL_CNT_W-1:0] FULL_CNT_MAX   = FULL_CNT_W'(NUM_BANKS);

    // Cycles from an accepted read strobe to rd_data/rd_valid.
    function automatic int unsigned calc_rd_latency(input int unsigned output_reg);
        return (output_reg != 0) ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/ipsxb_fft_sdpram_core.sv
// Single-clock simple dual-port RAM with optional output register.
// The outward-facing data register resets asynchronously; the array does not.
module ipsxb_fft_sdpram_core #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 54,
    parameter int unsigned OUTPUT_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clk_en && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] ram_q;
            logic                  load_q;
            logic [DATA_WIDTH-1:0] out_q;

            // Array read stage stays reset-free so it can map onto block RAM.
            always_ff @(posedge clk) begin
                if (clk_en && rd_en) begin
                    ram_q <= mem[rd_addr];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    load_q <= 1'b0;
                    out_q  <= '0;
                end else if (clk_en) begin
                    load_q <= rd_en;
                    if (load_q) begin
                        out_q <= ram_q;
                    end
                end
            end

            assign rd_data = out_q;
        end else begin : g_no_out_reg
            logic [DATA_WIDTH-1:0] ram_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ram_q <= '0;
                end else if (clk_en && rd_en) begin
                    ram_q <= mem[rd_addr];
                end
            end

            assign rd_data = ram_q;
        end
    endgenerate

endmodule

// File: rtl/ipsxb_fft_drm_pingpong_buf.sv
// Two-bank ping-pong frame buffer between FFT stages.
// Bank ownership moves on frame-done handshakes; misuse raises sticky error flags.
module ipsxb_fft_drm_pingpong_buf
    import ipsxb_fft_pingpong_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 54,
    parameter int unsigned OUTPUT_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_en,
    input  logic                  wr_frame_done,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_en,
    input  logic                  rd_frame_done,
    output logic                  rd_frame_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned RD_LAT  = calc_rd_latency(OUTPUT_REG);
    localparam int unsigned RAM_AW  = ADDR_WIDTH + BANK_W;

    logic [BANK_W-1:0]     wr_bank;
    logic [BANK_W-1:0]     rd_bank;
    logic [FULL_CNT_W-1:0] full_cnt;
    logic [FULL_CNT_W-1:0] full_cnt_nxt_c;
    logic [RD_LAT-1:0]     vld_pipe;

    logic wr_accept_c;
    logic rd_issue_c;
    logic wr_done_ok_c;
    logic rd_done_ok_c;
    logic overflow_nxt_c;
    logic underflow_nxt_c;

    assign wr_ready       = (full_cnt != FULL_CNT_MAX);
    assign rd_frame_valid = (full_cnt != FULL_CNT_EMPTY);

    // Handshake qualification and error detection.
    always_comb begin
        wr_accept_c     = 1'b0;
        rd_issue_c      = 1'b0;
        wr_done_ok_c    = 1'b0;
        rd_done_ok_c    = 1'b0;
        overflow_nxt_c  = overflow;
        underflow_nxt_c = underflow;
        full_cnt_nxt_c  = full_cnt;

        wr_accept_c  = wr_en && wr_ready;
        rd_issue_c   = rd_en && rd_frame_valid;
        wr_done_ok_c = wr_frame_done && wr_ready;
        rd_done_ok_c = rd_frame_done && rd_frame_valid;

        if ((wr_en || wr_frame_done) && !wr_ready) begin
            overflow_nxt_c = 1'b1;
        end
        if ((rd_en || rd_frame_done) && !rd_frame_valid) begin
            underflow_nxt_c = 1'b1;
        end

        // Simultaneous fill and release leave the count unchanged.
        case ({wr_done_ok_c, rd_done_ok_c})
            2'b10:   full_cnt_nxt_c = full_cnt + FULL_CNT_W'(1);
            2'b01:   full_cnt_nxt_c = full_cnt - FULL_CNT_W'(1);
            default: full_cnt_nxt_c = full_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank   <= '0;
            rd_bank   <= '0;
            full_cnt  <= FULL_CNT_EMPTY;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clk_en) begin
            if (wr_done_ok_c) begin
                wr_bank <= wr_bank + BANK_W'(1);
            end
            if (rd_done_ok_c) begin
                rd_bank <= rd_bank + BANK_W'(1);
            end
            full_cnt  <= full_cnt_nxt_c;
            overflow  <= overflow_nxt_c;
            underflow <= underflow_nxt_c;
        end
    end

    // rd_valid tracks accepted reads through the RAM pipeline depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (clk_en) begin
            vld_pipe[0] <= rd_issue_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LAT-1];

    ipsxb_fft_sdpram_core #(
        .ADDR_WIDTH (RAM_AW),
        .DATA_WIDTH (DATA_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .wr_en   (wr_accept_c),
        .wr_addr ({wr_bank, wr_addr}),
        .wr_data (wr_data),
        .rd_en   (rd_issue_c),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ipsxb_fft_drm_pingpong_buf.sv
// Bench for the ping-pong frame buffer: latency-2 and latency-1 instances share stimulus.
// Handshake vectors from a table, plus frame streaming, freeze and reset sequences.
module tb_ipsxb_fft_drm_pingpong_buf;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 54;
    localparam int          FRAME = 1 << AW;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          wr_fd;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          rd_fd;

    logic          wr_ready1, rfv1, rd_valid1, ovf1, udf1;
    logic [DW-1:0] rd_data1;
    logic          wr_ready0, rfv0, rd_valid0, ovf0, udf0;
    logic [DW-1:0] rd_data0;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } pend_t;

    pend_t         p1, p2;
    logic [DW-1:0] last1, last0;
    logic          cur_issue;
    logic [DW-1:0] cur_data;

    // stim = {wr_en, wr_fd, rd_en, rd_fd}; exp = {wr_ready, rd_frame_valid, overflow, underflow}
    typedef struct {
        logic [3:0] stim;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [10];

    ipsxb_fft_drm_pingpong_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_frame_done(wr_fd), .wr_ready(wr_ready1),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_frame_done(rd_fd),
        .rd_frame_valid(rfv1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .overflow(ovf1), .underflow(udf1)
    );

    ipsxb_fft_drm_pingpong_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_frame_done(wr_fd), .wr_ready(wr_ready0),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_frame_done(rd_fd),
        .rd_frame_valid(rfv0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .overflow(ovf0), .underflow(udf0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mk(input int tag, input int a);
        return (DW'(tag) << 16) | DW'(a);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_model();
        p1    = '0;
        p2    = '0;
        last1 = '0;
        last0 = '0;
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_fd     = 1'b0;
        rd_en     = 1'b0;
        rd_fd     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        cur_issue = 1'b0;
        cur_data  = '0;
    endtask

    // One clock; advance the read-pipeline model and check both read ports.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            clear_model();
        end else if (clk_en) begin
            p2 = p1;
            p1 = '{v: cur_issue, d: cur_data};
        end
        if (p1.v) last0 = p1.d;
        if (p2.v) last1 = p2.d;
        chk1("rd_valid_lat2", rd_valid1, p2.v);
        chkd("rd_data_lat2", rd_data1, last1);
        chk1("rd_valid_lat1", rd_valid0, p1.v);
        chkd("rd_data_lat1", rd_data0, last0);
    endtask

    task automatic chk_flags(input string name, input logic e_wr_ready, input logic e_rfv,
                             input logic e_ovf, input logic e_udf);
        chk1({name, "_wr_ready"}, wr_ready1, e_wr_ready);
        chk1({name, "_rd_frame_valid"}, rfv1, e_rfv);
        chk1({name, "_overflow"}, ovf1, e_ovf);
        chk1({name, "_underflow"}, udf1, e_udf);
        chk1({name, "_wr_ready_lat1"}, wr_ready0, e_wr_ready);
        chk1({name, "_rd_frame_valid_lat1"}, rfv0, e_rfv);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        clear_model();
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic write_frame(input int tag);
        for (int a = 0; a < FRAME; a++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(a);
            wr_data = mk(tag, a);
            wr_fd   = (a == FRAME - 1);
            step();
        end
        idle_inputs();
    endtask

    // Read frame rtag (release on last word); optionally write frame wtag alongside.
    task automatic stream(input int rtag, input int wtag, input int freeze_at);
        for (int a = 0; a < FRAME; a++) begin
            if (a == freeze_at) begin
                clk_en    = 1'b0;
                wr_en     = 1'b0;
                wr_fd     = 1'b1;
                rd_fd     = 1'b1;
                rd_en     = 1'b1;
                rd_addr   = AW'(a);
                cur_issue = 1'b0;
                repeat (10) begin
                    step();
                    chk_flags("freeze", 1'b1, 1'b1, 1'b0, 1'b0);
                end
                clk_en = 1'b1;
                wr_fd  = 1'b0;
            end
            rd_en     = 1'b1;
            rd_addr   = AW'(a);
            rd_fd     = (a == FRAME - 1);
            cur_issue = 1'b1;
            cur_data  = mk(rtag, a);
            if (wtag >= 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'(a);
                wr_data = mk(wtag, a);
                wr_fd   = (a == FRAME - 1);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk_en   = 1'b1;
        rst      = 1'b0;
        idle_inputs();
        clear_model();

        vecs[0] = '{stim: 4'b0010, exp: 4'b1001};
        vecs[1] = '{stim: 4'b0001, exp: 4'b1001};
        vecs[2] = '{stim: 4'b0100, exp: 4'b1101};
        vecs[3] = '{stim: 4'b0100, exp: 4'b0101};
        vecs[4] = '{stim: 4'b1000, exp: 4'b0111};
        vecs[5] = '{stim: 4'b0100, exp: 4'b0111};
        vecs[6] = '{stim: 4'b0001, exp: 4'b1111};
        vecs[7] = '{stim: 4'b0101, exp: 4'b1111};
        vecs[8] = '{stim: 4'b0001, exp: 4'b1011};
        vecs[9] = '{stim: 4'b0000, exp: 4'b1011};

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk_flags("por", 1'b1, 1'b0, 1'b0, 1'b0);
        chk1("por_rd_valid", rd_valid1, 1'b0);
        chkd("por_rd_data", rd_data1, '0);
        chk1("por_rd_valid_lat1", rd_valid0, 1'b0);
        chkd("por_rd_data_lat1", rd_data0, '0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Handshake and error-flag table.
        for (int i = 0; i < 10; i++) begin
            wr_en = vecs[i].stim[3];
            wr_fd = vecs[i].stim[2];
            rd_en = vecs[i].stim[1];
            rd_fd = vecs[i].stim[0];
            step();
            chk_flags($sformatf("vec%0d", i), vecs[i].exp[3], vecs[i].exp[2],
                      vecs[i].exp[1], vecs[i].exp[0]);
        end
        do_reset();
        chk_flags("post_table_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // Frame A fills bank 0; frame-done on the last write.
        write_frame(1);
        chk_flags("frame_a_done", 1'b1, 1'b1, 1'b0, 1'b0);

        // Read A while writing B; both frame-done pulses together keep the count at 1.
        stream(1, 2, -1);
        chk_flags("swap_ab", 1'b1, 1'b1, 1'b0, 1'b0);

        // Read B with a 10-cycle clock-enable freeze mid-frame.
        stream(2, -1, 200);
        chk_flags("frame_b_read", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step();

        // Underflow on empty buffer; spurious release ignored.
        rd_en = 1'b1;
        step();
        chk_flags("udf_rd", 1'b1, 1'b0, 1'b0, 1'b1);
        rd_en = 1'b0;
        rd_fd = 1'b1;
        step();
        rd_fd = 1'b0;
        chk_flags("udf_fd", 1'b1, 1'b0, 1'b0, 1'b1);

        // Two frames without reading; extra write and frame-done are dropped.
        write_frame(3);
        chk_flags("frame_c_done", 1'b1, 1'b1, 1'b0, 1'b1);
        write_frame(4);
        chk_flags("frame_d_done", 1'b0, 1'b1, 1'b0, 1'b1);
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = mk(99, 5);
        step();
        idle_inputs();
        chk_flags("ovf_wr", 1'b0, 1'b1, 1'b1, 1'b1);
        wr_fd = 1'b1;
        step();
        wr_fd = 1'b0;
        chk_flags("ovf_fd", 1'b0, 1'b1, 1'b1, 1'b1);
        stream(3, -1, -1);
        chk_flags("frame_c_read", 1'b1, 1'b1, 1'b1, 1'b1);
        stream(4, -1, -1);
        chk_flags("frame_d_read", 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) step();

        // Reset mid-frame with one frame pending and reads in flight.
        write_frame(5);
        chk_flags("frame_e_done", 1'b1, 1'b1, 1'b1, 1'b1);
        for (int a = 0; a < 10; a++) begin
            rd_en     = 1'b1;
            rd_addr   = AW'(a);
            cur_issue = 1'b1;
            cur_data  = mk(5, a);
            wr_en     = 1'b1;
            wr_addr   = AW'(a);
            wr_data   = mk(6, a);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk1("mid_rst_rd_valid", rd_valid1, 1'b0);
        chkd("mid_rst_rd_data", rd_data1, '0);
        chk1("mid_rst_rd_valid_lat1", rd_valid0, 1'b0);
        chkd("mid_rst_rd_data_lat1", rd_data0, '0);
        clear_model();
        idle_inputs();
        repeat (2) step();
        rst = 1'b0;
        step();
        chk_flags("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ipsxb_fft_drm_pingpong_buf.md
# ipsxb_fft_drm_pingpong_buf

Parametrised two-bank ping-pong frame buffer built on a single-clock simple dual-port RAM. It sits between FFT stages: one side writes a full frame of samples while the other side reads the previously completed frame. Bank ownership passes by frame-done handshakes, with overflow and underflow detection. It replaces ad-hoc pairs of fixed-width sdpram instances with one width/depth-generic block.

## Interface
- ADDR_WIDTH, 9: per-bank address width; frame depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 54: word width, 1..1152.
- OUTPUT_REG, 1: 1 adds a read output register (read latency 2); 0 gives read latency 1.
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- clk_en  input  1  global clock enable; when 0, all state holds, including the RAM, pointers, pipeline and flags.
- wr_data  input  DATA_WIDTH  write word.
- wr_addr  input  ADDR_WIDTH  write address within the current write bank.
- wr_en  input  1  write strobe.
- wr_frame_done  input  1  single-cycle pulse; the writer has completed the current bank.
- wr_ready  output  1  a write bank is free.
- rd_addr  input  ADDR_WIDTH  read address within the current read bank.
- rd_en  input  1  read strobe.
- rd_frame_done  input  1  single-cycle pulse; the reader releases the current bank.
- rd_frame_valid  output  1  a completed frame is available.
- rd_data  output  DATA_WIDTH  read word.
- rd_valid  output  1  qualifies rd_data.
- overflow  output  1  sticky error flag; cleared only by rst.
- underflow  output  1  sticky error flag; cleared only by rst.

## Operation
- State registers:
  - wr_bank and rd_bank, 1 bit each.
  - full_cnt, 2 bits, range 0..2.
- Combinational outputs: wr_ready = (full_cnt != 2); rd_frame_valid = (full_cnt != 0).
- RAM address: {wr_bank, wr_addr} on the write side, {rd_bank, rd_addr} on the read side. Total depth is 2^(ADDR_WIDTH+1).
- Write acceptance: the write is performed when wr_en & wr_ready. If wr_en & !wr_ready, the write is dropped and overflow is set.
- Accepted wr_frame_done (wr_frame_done & wr_ready): wr_bank toggles and full_cnt increments. If wr_frame_done & !wr_ready, the pulse is ignored and overflow is set.
- Read issue: the read is issued when rd_en & rd_frame_valid. If rd_en & !rd_frame_valid, no read is issued, no rd_valid follows, and underflow is set.
- Accepted rd_frame_done (rd_frame_done & rd_frame_valid): rd_bank toggles and full_cnt decrements. If rd_frame_done & !rd_frame_valid, the pulse is ignored and underflow is set.
- Both frame-done pulses accepted in the same cycle: both banks toggle and full_cnt is unchanged.
- No read/write collision can occur. wr_bank == rd_bank only when full_cnt is 0 (reads blocked) or 2 (writes blocked), so no bypass logic is needed.
- Same-cycle write and wr_frame_done: the write lands in the old bank, then the bank toggles.
- Same-cycle rd_en and rd_frame_done: the read uses the old rd_bank, and the returned data comes from that bank.
- Reset values:
  - wr_bank = 0, rd_bank = 0, full_cnt = 0.
  - wr_ready = 1, rd_frame_valid = 0.
  - rd_valid = 0, rd_data = 0.
  - overflow = 0, underflow = 0.
  - RAM contents are not reset.
- Reset asserted mid-frame discards all frames immediately. Partially written data is not recoverable.

## Timing
- Write latency: a word written in cycle N is readable by an issued read from cycle N+1.
- Read latency, OUTPUT_REG=1: rd_en accepted at cycle N gives rd_data/rd_valid at cycle N+2.
- Read latency, OUTPUT_REG=0: rd_en accepted at cycle N gives rd_data/rd_valid at cycle N+1.
- rd_valid is a pipelined copy of read acceptance. rd_data holds its last value when rd_valid is 0.
- Frame-done effects are visible on wr_ready/rd_frame_valid in the cycle after the pulse.
- Full throughput: one write plus one read per cycle, with no bubbles at frame boundaries.
- Error flags assert the cycle after the offending event.

## Structure
- Package ipsxb_fft_pingpong_pkg holds:
  - localparam NUM_BANKS = 2 and the full_cnt width.
  - Function calc_rd_latency(OUTPUT_REG).
- Sub-module ipsxb_fft_sdpram_core: inferred single-clock simple dual-port RAM with optional output register and async-reset output register. The ping-pong control (pointers, counter, flags, valid pipeline) lives in the top module.

## Test plan
- Reset, then write addrs 0..511 with data = addr, then pulse wr_frame_done. Expect rd_frame_valid=1 next cycle, then reads of addrs 0..511 return data = addr at 2-cycle latency.
- Write two frames without reading. Expect wr_ready=0 after the second wr_frame_done. A further wr_en is dropped, overflow=1, and both frames read back intact.
- Pulse wr_frame_done and rd_frame_done in the same cycle with full_cnt=1. Expect full_cnt to stay 1 and both banks to toggle. The next frame reads the bank written before.
- Assert rd_en with full_cnt=0. Expect no rd_valid and underflow=1. A spurious rd_frame_done leaves full_cnt at 0.
- Run with clk_en=0 for 10 cycles mid-frame. Expect outputs and pointers frozen and the data stream unbroken after re-enable. Repeat the sequence with OUTPUT_REG=0 and expect latency 1.
- Assert rst mid-frame with full_cnt=1. Expect wr_ready=1, rd_frame_valid=0, rd_valid=0 and flags cleared immediately, without waiting for a clock edge.
